// File: rtl/instr_fetch_unit.sv
// Fetch stage: gathers NBEATS narrow ROM beats (MSB first) into one instruction, then pulses core_en once.
// NBEATS+1 cycles per instruction on a zero-wait ROM; halt parks the fetched word, a silent ROM latches fetch_err.
module instr_fetch_unit #(
  parameter  int PC_WIDTH    = 8,
  parameter  int INSTR_WIDTH = 24,
  parameter  int BUS_WIDTH   = 8,
  parameter  int TIMEOUT     = 15,
  localparam int NBEATS      = INSTR_WIDTH / BUS_WIDTH,
  localparam int AW          = PC_WIDTH + $clog2(NBEATS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   core_en,
  output logic                   rom_req,
  output logic [AW-1:0]          rom_addr,
  input  logic                   rom_ack,
  input  logic [BUS_WIDTH-1:0]   rom_data,
  input  logic                   halt,
  output logic                   halted,
  output logic                   fetch_err
);

  localparam int BW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(NBEATS - 1);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t                 r_state;
  logic [BW-1:0]          r_beat;
  logic [WW-1:0]          r_wait;
  logic [INSTR_WIDTH-1:0] r_asm;
  logic [INSTR_WIDTH-1:0] r_instr;

  state_t                 w_next_state;
  logic [BW-1:0]          w_beat_next;
  logic [WW-1:0]          w_wait_next;
  logic [INSTR_WIDTH-1:0] w_asm_next;
  logic                   w_hs;
  logic                   w_load_instr;

  // rom_req is gated by reset so it drops the instant reset is asserted.
  assign rom_req   = (r_state == FETCH) && !reset;
  assign core_en   = (r_state == EXEC);
  assign halted    = (r_state == HOLD);
  assign fetch_err = (r_state == ERR);
  assign instr     = r_instr;
  assign rom_addr  = AW'(pc) * AW'(NBEATS) + AW'(r_beat);
  assign w_hs      = rom_req && rom_ack;

  // Current beat's byte dropped into its MSB-first slot of the assembly word.
  always_comb begin
    w_asm_next = r_asm;
    for (int k = 0; k < NBEATS; k++) begin
      if (r_beat == BW'(k)) begin
        w_asm_next[INSTR_WIDTH-1-k*BUS_WIDTH -: BUS_WIDTH] = rom_data;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_beat_next  = r_beat;
    w_wait_next  = r_wait;
    w_load_instr = 1'b0;
    case (r_state)
      FETCH: begin
        if (w_hs) begin
          w_wait_next = '0;
          if (r_beat == LAST_BEAT) begin
            w_beat_next  = '0;
            w_load_instr = 1'b1;
            w_next_state = halt ? HOLD : EXEC;
          end else begin
            w_beat_next = r_beat + BW'(1);
          end
        end else begin
          w_wait_next = r_wait + WW'(1);
          if (r_wait == WAIT_LIMIT) begin
            w_next_state = ERR;
          end
        end
      end
      EXEC: begin
        w_wait_next  = '0;
        w_next_state = FETCH;
      end
      HOLD: begin
        if (!halt) begin
          w_next_state = EXEC;
        end
      end
      ERR: begin
        w_next_state = ERR;
      end
      default: begin
        w_next_state = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
      r_beat  <= '0;
      r_wait  <= '0;
      r_asm   <= '0;
      r_instr <= '0;
    end else begin
      r_state <= w_next_state;
      r_beat  <= w_beat_next;
      r_wait  <= w_wait_next;
      if (w_hs) begin
        r_asm <= w_asm_next;
      end
      if (w_load_instr) begin
        r_instr <= w_asm_next;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: ROM responder, core pc model and a transaction-level scoreboard,
// plus directed scenarios with literal expectations.
module tb_instr_fetch_unit;

  localparam int PCW  = 8;
  localparam int IW   = 24;
  localparam int BUSW = 8;
  localparam int TO   = 15;
  localparam int NB   = 3;
  localparam int AW   = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic [PCW-1:0]  pc;
  logic [IW-1:0]   instr;
  logic            core_en;
  logic            rom_req;
  logic [AW-1:0]   rom_addr;
  logic            rom_ack;
  logic [BUSW-1:0] rom_data;
  logic            halt;
  logic            halted;
  logic            fetch_err;

  instr_fetch_unit #(
    .PC_WIDTH   (PCW),
    .INSTR_WIDTH(IW),
    .BUS_WIDTH  (BUSW),
    .TIMEOUT    (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .instr    (instr),
    .core_en  (core_en),
    .rom_req  (rom_req),
    .rom_addr (rom_addr),
    .rom_ack  (rom_ack),
    .rom_data (rom_data),
    .halt     (halt),
    .halted   (halted),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] rom_mem [0:1023];
  int         ack_delay = 0;
  bit         ack_en = 1'b1;
  bit         branch_en = 1'b0;
  logic [7:0] branch_tgt = 8'h00;
  bit         pc_update_due = 1'b0;

  // Scoreboard state: beats received for the current word, whether a word awaits execution,
  // whether it has been released past halt, and the timeout bookkeeping.
  int          m_beats = 0;
  bit          m_pending = 1'b0;
  bit          m_released = 1'b0;
  bit          m_err = 1'b0;
  int          m_wait_run = 0;
  logic [23:0] m_instr = '0;
  bit          prev_core_en = 1'b0;
  int          wcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] word_at(input logic [7:0] p);
    int a;
    a = int'(p) * 3;
    return {rom_mem[a], rom_mem[a+1], rom_mem[a+2]};
  endfunction

  // Monitor, ROM responder and scoreboard; everything happens at the falling edge.
  initial begin
    rom_ack  = 1'b0;
    rom_data = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_rom_req", rom_req, 0);
        chk("rst_core_en", core_en, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fetch_err", fetch_err, 0);
        chk("rst_instr", instr, 0);
        m_beats = 0; m_pending = 0; m_released = 0; m_err = 0;
        m_wait_run = 0; m_instr = '0; prev_core_en = 0; wcnt = 0;
        rom_ack = 1'b0;
      end else begin
        chk("rom_req", rom_req, !m_pending && !m_err);
        chk("core_en", core_en, m_pending && m_released);
        chk("halted", halted, m_pending && !m_released);
        chk("fetch_err", fetch_err, m_err);
        chk("instr", instr, m_instr);
        chk("core_en_with_rom_req", core_en && rom_req, 0);
        chk("core_en_back_to_back", core_en && prev_core_en, 0);
        if (rom_req) chk("rom_addr", rom_addr, int'(pc) * NB + m_beats);
        prev_core_en = core_en;
        if (rom_req && ack_en && wcnt >= ack_delay) begin
          rom_ack  = 1'b1;
          rom_data = rom_mem[rom_addr];
        end else begin
          rom_ack  = 1'b0;
          rom_data = 8'hEE;
        end
        if (m_pending) begin
          if (m_released) begin
            m_pending = 0; m_released = 0; pc_update_due = 1;
          end else if (!halt) begin
            m_released = 1;
          end
        end else if (!m_err && rom_req) begin
          if (rom_ack) begin
            wcnt = 0; m_wait_run = 0; m_beats++;
            if (m_beats == NB) begin
              m_beats = 0; m_pending = 1; m_instr = word_at(pc); m_released = !halt;
            end
          end else begin
            wcnt++; m_wait_run++;
            if (m_wait_run == TO) m_err = 1;
          end
        end
      end
    end
  end

  // Core: advances pc (or takes a branch) on the edge that ends a core_en cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pc_update_due) begin
        pc_update_due = 0;
        if (branch_en) begin
          pc = branch_tgt;
          branch_en = 0;
        end else begin
          pc = pc + 8'd1;
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 8'((i * 37 + 11) & 255);
    rom_mem[0]   = 8'h12; rom_mem[1]   = 8'h34; rom_mem[2]   = 8'h56;
    rom_mem[15]  = 8'hDE; rom_mem[16]  = 8'hAD; rom_mem[17]  = 8'hBF;
    rom_mem[192] = 8'hA1; rom_mem[193] = 8'hB2; rom_mem[194] = 8'hC3;
    rom_mem[195] = 8'h11; rom_mem[196] = 8'h22; rom_mem[197] = 8'h33;
    rom_mem[198] = 8'h5A; rom_mem[199] = 8'hC3; rom_mem[200] = 8'h3C;
    rom_mem[201] = 8'h9F; rom_mem[202] = 8'h01; rom_mem[203] = 8'h7E;
    rom_mem[765] = 8'hF0; rom_mem[766] = 8'h0D; rom_mem[767] = 8'hE1;
    pc = 8'h00; halt = 1'b0; reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    branch_en = 1; branch_tgt = 8'h05;
    reset = 1'b0;

    // Zero-wait ROM at pc 0.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("t1_addr", rom_addr, k); chk("t1_req", rom_req, 1);
    end
    @(negedge clk);
    chk("t1_core_en", core_en, 1); chk("t1_instr", instr, 24'h123456); chk("t1_req_low", rom_req, 0);

    // pc 5 with two wait cycles per beat, then a branch to 0x40.
    @(posedge clk); #2;
    ack_delay = 2; branch_en = 1; branch_tgt = 8'h40;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); chk("t2_addr", rom_addr, 15 + k / 3); chk("t2_no_core_en", core_en, 0);
    end
    @(negedge clk);
    chk("t2_core_en", core_en, 1); chk("t2_instr", instr, 24'hDEADBF);
    @(posedge clk); #2;
    ack_delay = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("t3_addr", rom_addr, 192 + k); chk("t3_req", rom_req, 1);
    end
    @(negedge clk);
    chk("t3_core_en", core_en, 1); chk("t3_instr", instr, 24'hA1B2C3);

    // Halt on the final beat of pc 0x41.
    @(negedge clk); chk("t4_addr0", rom_addr, 195);
    @(negedge clk); chk("t4_addr1", rom_addr, 196);
    @(posedge clk); #2; halt = 1'b1;
    @(negedge clk); chk("t4_addr2", rom_addr, 197);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t4_halted", halted, 1); chk("t4_no_core_en", core_en, 0); chk("t4_instr", instr, 24'h112233);
    end
    @(posedge clk); #2; halt = 1'b0;
    @(negedge clk); chk("t4_still_halted", halted, 1); chk("t4_core_en_wait", core_en, 0);
    @(negedge clk); chk("t4_core_en", core_en, 1); chk("t4_halted_low", halted, 0);

    // ROM never answers at pc 0x42.
    @(posedge clk); #2; ack_en = 0;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      chk("t5_req", rom_req, 1); chk("t5_err_low", fetch_err, 0); chk("t5_addr", rom_addr, 198);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t5_req_low", rom_req, 0); chk("t5_err", fetch_err, 1); chk("t5_no_core_en", core_en, 0);
    end
    @(posedge clk); #2; reset = 1'b1;
    #1; chk("t5_rst_err", fetch_err, 0); chk("t5_rst_req", rom_req, 0);
    ack_en = 1;
    repeat (2) @(posedge clk);
    #2; reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("t5_refetch_addr", rom_addr, 198 + k);
    end
    @(negedge clk); chk("t5_core_en", core_en, 1); chk("t5_instr", instr, 24'h5AC33C);

    // Asynchronous reset mid-cycle after the second beat of pc 0x43.
    @(posedge clk); #2; branch_en = 1; branch_tgt = 8'hFF;
    @(negedge clk); chk("t6_addr0", rom_addr, 201);
    @(negedge clk); chk("t6_addr1", rom_addr, 202);
    @(posedge clk); #3; reset = 1'b1;
    #1; chk("t6_req_drop", rom_req, 0); chk("t6_instr_drop", instr, 0);
    repeat (2) @(posedge clk);
    #3; reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("t6_restart_addr", rom_addr, 201 + k);
    end
    @(negedge clk); chk("t6_core_en", core_en, 1); chk("t6_instr", instr, 24'h9F017E);

    // Highest pc reaches the top of the ROM address space without wrap.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("t7_addr", rom_addr, 765 + k);
    end
    @(negedge clk); chk("t7_core_en", core_en, 1); chk("t7_instr", instr, 24'hF00DE1);

    // Mixed latencies with one halt, checked by the scoreboard.
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #2;
      ack_delay = n % 3;
      halt = (n == 2);
      seen = 0;
      for (int c = 0; c < 80 && !seen; c++) begin
        @(negedge clk);
        if (core_en) seen = 1;
        else if (halted && c > 5) begin
          @(posedge clk); #2; halt = 1'b0;
        end
      end
      chk("t8_core_en_seen", seen, 1);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the TP-ISA core. It reads each instruction word for the core's current pc from a narrow, variable-latency program ROM over several bus beats and assembles the beats into one instruction. It then presents the instruction to the core and pulses a one-cycle core enable, so the core advances exactly one instruction per fetch. The block also supports halt and hold, and detects ROM timeouts.

Parameters:
- PC_WIDTH, 8, width of the core pc.
- INSTR_WIDTH, 24, instruction word width. Must be an integer multiple of BUS_WIDTH.
- BUS_WIDTH, 8, ROM data bus width.
- TIMEOUT, 15, maximum consecutive cycles rom_req may wait for rom_ack.
- Derived: NBEATS = INSTR_WIDTH/BUS_WIDTH (default 3).
- Derived: AW = PC_WIDTH + $clog2(NBEATS) (default 10).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc  in  PC_WIDTH  current pc from the core. Stable while core_en=0.
- instr  out  INSTR_WIDTH  assembled instruction to the core.
- core_en  out  1  one-cycle pulse; the core executes instr and updates pc on this edge.
- rom_req  out  1  ROM read request.
- rom_addr  out  AW  ROM byte address, equal to pc*NBEATS + beat.
- rom_ack  in  1  ROM data valid; qualified by rom_req.
- rom_data  in  BUS_WIDTH  ROM read data.
- halt  in  1  request to stop the core after the current fetch.
- halted  out  1  high while a fetched instruction is held back by halt.
- fetch_err  out  1  sticky ROM timeout flag.

Behaviour:
- Reset (asynchronous, immediate):
  - Outputs: instr=0, core_en=0, rom_req=0, halted=0, fetch_err=0.
  - Internal: beat counter=0, wait counter=0, state=FETCH.
  - A partially assembled instruction is discarded.
  - The first rom_req is driven high in the first cycle after reset deasserts.
- States: FETCH, EXEC, HOLD, ERR.
- FETCH:
  - rom_req=1.
  - rom_addr = pc*NBEATS + beat, computed combinationally from the pc input and the beat counter. It is held stable until the beat's handshake.
  - A handshake is rom_req && rom_ack sampled at a rising edge. rom_ack without rom_req is ignored.
  - Beat ordering is MSB-first: beat k fills instr bits [INSTR_WIDTH-1-k*BUS_WIDTH -: BUS_WIDTH], so beat 0 carries the opcode/bmask byte.
  - Beats 0..NBEATS-2 go into an internal assembly register.
  - On the final-beat handshake, instr is loaded atomically from the assembly register plus rom_data. instr is otherwise unchanged.
  - After the final beat: go to HOLD if halt=1 in that cycle, else EXEC. The beat counter resets to 0.
  - On a non-final handshake, beat increments and rom_req stays high, so back-to-back beats are allowed. A zero-wait ROM gives one beat per cycle.
- Wait counter:
  - Counts consecutive FETCH cycles with rom_req=1 and rom_ack=0. It clears on every handshake.
  - When it reaches TIMEOUT without an ack, the next state is ERR.
- EXEC:
  - core_en=1 for exactly one cycle and rom_req=0. The next state is FETCH.
  - Halt asserted during EXEC does not suppress the pulse.
  - The core's new pc is used by the first FETCH cycle, which covers both sequential steps and branches with no special handling.
- HOLD:
  - halted=1, rom_req=0, core_en=0. instr is held.
  - When halt is sampled 0: halted drops and the next state is EXEC.
- ERR:
  - rom_req=0, core_en=0, fetch_err=1.
  - Exited only by reset.
- Throughput: NBEATS+1 cycles per instruction with a zero-wait ROM.
- Invariants:
  - core_en and rom_req are never high in the same cycle.
  - core_en is never high in two consecutive cycles.
  - rom_addr is constant while rom_req=1 and rom_ack=0.
- Arithmetic: rom_addr is computed at width AW. pc = 2^PC_WIDTH-1 produces the highest addresses without wrap. The pc wraps in the core, not here.

Test Plan:
- Zero-wait ROM, pc=0, ROM[0..2]=0x12,0x34,0x56 → rom_addr=0,1,2 in the first three post-reset cycles; cycle 4 has core_en=1 with instr=0x123456; rom_req low in cycle 4.
- pc=5, rom_ack delayed 2 cycles per beat → rom_addr held at 15, then 16, then 17 until each ack; exactly one core_en, in the cycle after the ack for address 17.
- Core branches from pc 5 to 0x40 at core_en → next fetch issues rom_addr 192,193,194; no access at 18.
- halt=1 during final-beat ack → halted=1, core_en stays 0 for 10 cycles with instr stable; halt=0 → core_en pulse in the next cycle and halted=0.
- rom_ack never asserted → after 15 waiting cycles rom_req=0 and fetch_err=1, persisting with no core_en until reset; after reset, fetch_err=0 and refetch starts at beat 0.
- Reset asserted asynchronously mid-cycle after the beat-1 handshake → rom_req and instr drop to 0 immediately; after release the fetch restarts at pc*3+0 and produces no corrupted instr.
